// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences core loads/stores onto a req/ack data-memory bus
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUOut,
  input  logic [31:0] rs2,
  output logic        stall,
  output logic [31:0] ReadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic        start;
  logic        mis_in;
  logic [1:0]  a;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  assign start = MemRead | MemWrite;
  assign a     = ALUOut[1:0];

  // funct3[1:0] alone selects the size: 00 byte, 01 half, anything else word
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = rs2;
    case (funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << a;
        wdata_in = {4{rs2[7:0]}};
      end
      2'b01: begin
        be_in    = a[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{rs2[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis_in = 1'b0;
    case (funct3[1:0])
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = a[0];
      default: mis_in = (a != 2'b00);
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic [7:0]  bv;
    logic [15:0] hv;
    bv = w[{lo, 3'b000} +: 8];
    hv = w[{lo[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, bv} : {{24{bv[7]}}, bv};
      2'b01:   return f3[2] ? {16'b0, hv} : {{16{hv[15]}}, hv};
      default: return w;
    endcase
  endfunction

  // The request cycle stalls before the FSM has left IDLE, so stall is partly combinational
  assign stall = !reset && ((state == S_REQ) || ((state == S_IDLE) && start));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= 8'd0;
      lo_q      <= 2'b00;
      f3_q      <= 3'b000;
      ReadData  <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_we    <= MemWrite;
            mem_addr  <= {ALUOut[31:2], 2'b00};
            mem_be    <= be_in;
            mem_wdata <= wdata_in;
            lo_q      <= a;
            f3_q      <= funct3;
            count     <= 8'd0;
            if (mis_in) begin
              state    <= S_DONE;
              misalign <= 1'b1;
              ReadData <= 32'd0;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            if (!mem_we) ReadData <= extract(mem_rdata, lo_q, f3_q);
          end else if (count == 8'(TIMEOUT - 1)) begin
            state    <= S_DONE;
            mem_req  <= 1'b0;
            bus_err  <= 1'b1;
            ReadData <= 32'd0;
          end else begin
            count <= count + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
